// File: rtl/pwm_multi.sv
// Multi-channel PWM generator.
// One shared period counter drives NUM_CH duty comparators. Period, duty and
// alignment mode are written into shadow registers by a load strobe and only
// reach the active registers at a period boundary (or while stopped), so a
// running waveform never sees a half-updated configuration.
module pwm_multi #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 21
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    center_mode,
   input  logic [CNT_W-1:0]        max_cnt,
   input  logic [NUM_CH*CNT_W-1:0] duty,
   input  logic                    load,
   output logic [NUM_CH-1:0]       PWM_sig,
   output logic                    period_done
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   dir_t                    dir_q, dir_d;

   logic [CNT_W-1:0]        shadowMax_q;
   logic [NUM_CH*CNT_W-1:0] shadowDuty_q;
   logic                    shadowCenter_q;
   logic                    pending_q, pending_d;

   logic [CNT_W-1:0]        activeMax_q;
   logic [NUM_CH*CNT_W-1:0] activeDuty_q;
   logic                    activeCenter_q;

   logic [NUM_CH-1:0]       pwm_q, pwm_d;
   logic                    periodDone_q, periodDone_d;

   logic                    lastValue;
   logic                    transfer;

   // Decide whether the counter sits on the final value of its period.
   // Center mode with a zero terminal count degenerates to edge mode; with a
   // terminal count of one the up-ramp peak is also the last value.
   always_comb begin
      lastValue = 1'b0;
      if (activeCenter_q && (activeMax_q != '0)) begin
         if (dir_q == DIR_DOWN) begin
            lastValue = (cnt_q == CNT_W'(1));
         end else begin
            lastValue = (cnt_q >= activeMax_q) && (activeMax_q == CNT_W'(1));
         end
      end else begin
         lastValue = (cnt_q >= activeMax_q);
      end
   end

   // Next counter value, direction, shadow-to-active handoff and outputs.
   // Leaving the last value restarts at zero counting up; a stopped counter
   // is held at zero and also lets a pending configuration through.
   always_comb begin
      cnt_d        = cnt_q;
      dir_d        = dir_q;
      pwm_d        = '0;
      periodDone_d = 1'b0;
      transfer     = 1'b0;
      pending_d    = pending_q;

      if (!en) begin
         cnt_d    = '0;
         dir_d    = DIR_UP;
         transfer = pending_q;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (cnt_q < activeDuty_q[i*CNT_W +: CNT_W]);
         end
         if (lastValue) begin
            cnt_d        = '0;
            dir_d        = DIR_UP;
            periodDone_d = 1'b1;
            transfer     = pending_q;
         end else if (activeCenter_q && (dir_q == DIR_UP) && (cnt_q >= activeMax_q)) begin
            cnt_d = cnt_q - CNT_W'(1);
            dir_d = DIR_DOWN;
         end else if (dir_q == DIR_DOWN) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (load) begin
         pending_d = 1'b1;
      end else if (transfer) begin
         pending_d = 1'b0;
      end
   end

   // State registers; the active set copies the pre-load shadow so a load on
   // a boundary edge waits for the following boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         dir_q          <= DIR_UP;
         shadowMax_q    <= '0;
         shadowDuty_q   <= '0;
         shadowCenter_q <= 1'b0;
         pending_q      <= 1'b0;
         activeMax_q    <= '0;
         activeDuty_q   <= '0;
         activeCenter_q <= 1'b0;
         pwm_q          <= '0;
         periodDone_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         pending_q    <= pending_d;
         pwm_q        <= pwm_d;
         periodDone_q <= periodDone_d;
         if (load) begin
            shadowMax_q    <= max_cnt;
            shadowDuty_q   <= duty;
            shadowCenter_q <= center_mode;
         end
         if (transfer) begin
            activeMax_q    <= shadowMax_q;
            activeDuty_q   <= shadowDuty_q;
            activeCenter_q <= shadowCenter_q;
         end
      end
   end

   assign PWM_sig     = pwm_q;
   assign period_done = periodDone_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: hand-computed vector table, directed multi-cycle
// sequences and randomized traffic against a phase-based reference model.
module tb_pwm_multi;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;

   logic                    clk;
   logic                    rst;
   logic                    en;
   logic                    centerMode;
   logic [CNT_W-1:0]        maxCnt;
   logic [NUM_CH*CNT_W-1:0] duty;
   logic                    load;
   logic [NUM_CH-1:0]       pwmSig;
   logic                    periodDone;

   pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .center_mode (centerMode),
      .max_cnt     (maxCnt),
      .duty        (duty),
      .load        (load),
      .PWM_sig     (pwmSig),
      .period_done (periodDone)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   bit checkPdEn = 1'b1;

   // Reference model: position inside the period is a phase index and the
   // counter value is derived from it arithmetically.
   int       mShMax, mShCenter, mPend;
   int       mShDuty  [NUM_CH];
   int       mActMax, mActCenter;
   int       mActDuty [NUM_CH];
   int       mPhase;
   bit [1:0] mPwm;
   bit       mPd;

   int hi0, hi1, pdCnt, run0, maxRun0;

   typedef struct {
      logic       en;
      logic       ld;
      logic       ctr;
      logic [7:0] mx;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] expPwm;
      logic       expPd;
   } vec_t;

   vec_t vecs[16];

   task automatic modelReset();
      mShMax = 0; mShCenter = 0; mPend = 0;
      mActMax = 0; mActCenter = 0; mPhase = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         mShDuty[i]  = 0;
         mActDuty[i] = 0;
      end
      mPwm = '0;
      mPd  = 1'b0;
   endtask

   task automatic modelStep(input bit e, input bit ld, input bit ctr,
                            input int mx, input int d0, input int d1);
      int period;
      int c;
      bit boundary;
      boundary = 1'b0;
      if (e) begin
         period = (mActCenter != 0 && mActMax > 0) ? 2 * mActMax : mActMax + 1;
         c = (mActCenter != 0 && mActMax > 0 && mPhase > mActMax) ? 2 * mActMax - mPhase : mPhase;
         for (int i = 0; i < NUM_CH; i++) mPwm[i] = (c < mActDuty[i]);
         if (mPhase == period - 1) begin
            mPhase   = 0;
            mPd      = 1'b1;
            boundary = 1'b1;
         end else begin
            mPhase = mPhase + 1;
            mPd    = 1'b0;
         end
      end else begin
         mPhase   = 0;
         mPwm     = '0;
         mPd      = 1'b0;
         boundary = 1'b1;
      end
      if (boundary && mPend != 0) begin
         mActMax    = mShMax;
         mActCenter = mShCenter;
         for (int i = 0; i < NUM_CH; i++) mActDuty[i] = mShDuty[i];
         mPend = 0;
      end
      if (ld) begin
         mShMax     = mx;
         mShCenter  = ctr;
         mShDuty[0] = d0;
         mShDuty[1] = d1;
         mPend      = 1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [1:0] expPwm,
                              input logic expPd, input bit usePd);
      total++;
      if (pwmSig !== expPwm || (usePd && periodDone !== expPd)) begin
         bad++;
         $display("[TB] FAIL %s: got pwm=%b pd=%b, want pwm=%b pd=%b%s",
                  name, pwmSig, periodDone, expPwm, expPd, usePd ? "" : " (pd ignored)");
      end
   endtask

   task automatic checkCount(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic clearCounts();
      hi0 = 0; hi1 = 0; pdCnt = 0; run0 = 0; maxRun0 = 0;
   endtask

   // Drive one cycle of inputs, step the model on the edge, compare 1 ns later.
   task automatic applyStimulus(input bit e, input bit ld, input bit ctr,
                                input int mx, input int d0, input int d1);
      en         = e;
      load       = ld;
      centerMode = ctr;
      maxCnt     = CNT_W'(mx);
      duty       = {CNT_W'(d1), CNT_W'(d0)};
      @(posedge clk);
      modelStep(e, ld, ctr, mx, d0, d1);
      #1;
      checkOutput("model", mPwm, mPd, checkPdEn);
      hi0   += int'(pwmSig[0]);
      hi1   += int'(pwmSig[1]);
      pdCnt += int'(periodDone);
      run0   = pwmSig[0] ? run0 + 1 : 0;
      if (run0 > maxRun0) maxRun0 = run0;
   endtask

   task automatic doReset();
      rst = 1'b1; en = 1'b0; load = 1'b0; centerMode = 1'b0;
      maxCnt = '0; duty = '0;
      @(posedge clk);
      #1;
      checkOutput("reset", 2'b00, 1'b0, 1'b1);
      rst = 1'b0;
      modelReset();
   endtask

   initial begin
      rst = 1'b1;
      modelReset();

      // en, ld, ctr, max, d0, d1, expected PWM_sig, expected period_done
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd3, 8'd1, 8'd4, 2'b00, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b00, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b11, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b10, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b10, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b10, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b11, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 2'b10, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 8'd0, 2'b10, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b10, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b01, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b00, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b01, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b00, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b01, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0, 2'b00, 1'b1};

      $display("[TB] vector table");
      doReset();
      for (int k = 0; k < 16; k++) begin
         applyStimulus(vecs[k].en, vecs[k].ld, vecs[k].ctr,
                       int'(vecs[k].mx), int'(vecs[k].d0), int'(vecs[k].d1));
         checkOutput($sformatf("vec%0d", k), vecs[k].expPwm, vecs[k].expPd, 1'b1);
      end

      $display("[TB] edge-aligned max=9 duty 3/10");
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 9, 3, 10);
      applyStimulus(1'b0, 1'b0, 1'b0, 9, 3, 10);
      clearCounts();
      repeat (30) applyStimulus(1'b1, 1'b0, 1'b0, 9, 3, 10);
      checkCount("edge ch0 highs", hi0, 9);
      checkCount("edge ch1 highs", hi1, 30);
      checkCount("edge period_done", pdCnt, 3);

      $display("[TB] center-aligned max=5 duty 2");
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b1, 5, 2, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 5, 2, 0);
      clearCounts();
      repeat (20) applyStimulus(1'b1, 1'b0, 1'b1, 5, 2, 0);
      checkCount("center ch0 highs", hi0, 6);
      checkCount("center ch0 pulse width", maxRun0, 3);
      checkCount("center ch1 highs", hi1, 0);
      checkCount("center period_done", pdCnt, 2);

      $display("[TB] mid-period and boundary loads");
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 9, 3, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 9, 3, 0);
      clearCounts();
      for (int t = 1; t <= 10; t++) applyStimulus(1'b1, t == 5, 1'b0, 9, (t == 5) ? 7 : 3, 0);
      checkCount("period keeps duty 3", hi0, 3);
      clearCounts();
      for (int t = 11; t <= 20; t++) applyStimulus(1'b1, 1'b0, 1'b0, 9, 7, 0);
      checkCount("next period duty 7", hi0, 7);
      clearCounts();
      for (int t = 21; t <= 30; t++)
         applyStimulus(1'b1, (t == 25) || (t == 30), 1'b0, 9, (t == 30) ? 5 : 2, 0);
      checkCount("period before boundary load", hi0, 7);
      clearCounts();
      for (int t = 31; t <= 40; t++) applyStimulus(1'b1, 1'b0, 1'b0, 9, 5, 0);
      checkCount("pre-load shadow duty 2", hi0, 2);
      clearCounts();
      for (int t = 41; t <= 50; t++) applyStimulus(1'b1, 1'b0, 1'b0, 9, 5, 0);
      checkCount("boundary-loaded duty 5", hi0, 5);

      $display("[TB] duty 0 and duty max+1");
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 9, 0, 10);
      applyStimulus(1'b0, 1'b0, 1'b0, 9, 0, 10);
      clearCounts();
      repeat (30) applyStimulus(1'b1, 1'b0, 1'b0, 9, 0, 10);
      checkCount("duty0 constant low", hi0, 0);
      checkCount("duty max+1 constant high", hi1, 30);

      $display("[TB] asynchronous reset mid-period");
      applyStimulus(1'b1, 1'b0, 1'b0, 9, 0, 10);
      applyStimulus(1'b1, 1'b1, 1'b0, 9, 4, 4);
      #2 rst = 1'b1;
      #1 checkOutput("async reset outputs", 2'b00, 1'b0, 1'b1);
      #1 rst = 1'b0;
      modelReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 9, 4, 4);
      checkPdEn = 1'b0;
      clearCounts();
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 9, 4, 4);
      checkPdEn = 1'b1;
      checkCount("pending lost ch0", hi0, 0);
      checkCount("pending lost ch1", hi1, 0);

      $display("[TB] randomized traffic");
      doReset();
      for (int n = 0; n < 800; n++) begin
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                       int'($urandom_range(0, 14)), int'($urandom_range(0, 14)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
